// File: rtl/io_keysw_device.sv
// -----------------------------------------------------------------------------
// io_keysw_device
//   Memory-mapped key/switch input peripheral. Four active-low keys and ten
//   active-high switches are synchronized and debounced. The processor reads
//   them through two data registers. Two control registers hold a ready flag,
//   an overrun flag and an interrupt enable for each input group.
//
//   Register map (16-bit byte addresses):
//     FFF0 KDATA  (RO) {12'b0, pressed keys}
//     FFF2 SDATA  (RO) {6'b0, debounced switches}
//     FFF4 KCTRL  (RW) bit0 RDY (RO), bit1 OVR (write 0 clears), bit4 IE
//     FFF6 SCTRL  (RW) same layout as KCTRL, for the switches
//     other       reads 16'hDEAD
//
// Ports
//   clk       system clock; all state changes on its rising edge
//   reset     synchronous, active-high reset
//   dmemaddr  bus byte address
//   dmemin    store data
//   wrmem     store strobe (one cycle per store)
//   rdmem     load strobe (a load from a data register clears its RDY)
//   dmemout   load data, combinational from dmemaddr and register state
//   KEY       raw keys, asynchronous, active-low
//   SW        raw switches, asynchronous, active-high
//   irq       level interrupt, decoded from registered state only
// -----------------------------------------------------------------------------
module io_keysw_device #(
   parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] dmemaddr,
   input  logic [15:0] dmemin,
   input  logic        wrmem,
   input  logic        rdmem,
   output logic [15:0] dmemout,
   input  logic [3:0]  KEY,
   input  logic [9:0]  SW,
   output logic        irq
);

   localparam logic [15:0] ADDR_KDATA = 16'hFFF0;
   localparam logic [15:0] ADDR_SDATA = 16'hFFF2;
   localparam logic [15:0] ADDR_KCTRL = 16'hFFF4;
   localparam logic [15:0] ADDR_SCTRL = 16'hFFF6;

   // Keys and switches share one input vector: bits [3:0] KEY, [13:4] SW.
   // Keys idle high (not pressed), switches idle low.
   localparam int          NB      = 14;
   localparam logic [NB-1:0] IN_RST = {10'b0, 4'hF};

   typedef struct packed {
      logic ie;
      logic ovr;
      logic rdy;
   } ctrl_t;

   logic [NB-1:0]       sync1, sync2, deb, deb_nxt;
   logic [NB-1:0][15:0] cnt, cnt_nxt;
   ctrl_t               kctrl, sctrl, kctrl_nxt, sctrl_nxt;
   logic                key_evt, sw_evt;
   logic                key_clr, sw_clr, kctrl_wr, sctrl_wr;

   // Only dmemin[1] (OVR) and dmemin[4] (IE) are writable.
   logic unused_dmemin;
   assign unused_dmemin = ^{dmemin[15:5], dmemin[3:2], dmemin[0]};

   // Debounce: a bit's counter runs only while the synchronized sample
   // disagrees with the debounced value. On the edge that completes
   // DEB_CYCLES disagreeing samples, the debounced bit takes the sample.
   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first so no
      // path through the loop can leave it unassigned and infer a latch.
      deb_nxt = deb;
      cnt_nxt = '0;
      for (int i = 0; i < NB; i++) begin
         if (sync2[i] != deb[i]) begin
            if (cnt[i] == DEB_CYCLES - 16'd1) begin
               deb_nxt[i] = sync2[i];
            end else begin
               cnt_nxt[i] = cnt[i] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the counter array is plain flops, not a RAM, so it is reset along
      // with everything else to discard any debounce in progress.
      if (reset) begin
         sync1 <= IN_RST;
         sync2 <= IN_RST;
         deb   <= IN_RST;
         cnt   <= '0;
      end else begin
         // NOTE: non-blocking assignments let sync2 take the old sync1,
         // which is what forms the two-flop chain.
         sync1 <= {SW, KEY};
         sync2 <= sync1;
         deb   <= deb_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign key_evt  = (deb_nxt[3:0]  != deb[3:0]);
   assign sw_evt   = (deb_nxt[13:4] != deb[13:4]);
   assign key_clr  = rdmem && (dmemaddr == ADDR_KDATA);
   assign sw_clr   = rdmem && (dmemaddr == ADDR_SDATA);
   assign kctrl_wr = wrmem && (dmemaddr == ADDR_KCTRL);
   assign sctrl_wr = wrmem && (dmemaddr == ADDR_SCTRL);

   // A new event always wins. RDY is set even when a clearing load lands on
   // the same edge. OVR is set even when a store tries to clear it.
   // A change that coincides with a clearing load is not an overrun.
   function automatic ctrl_t ctrl_update(input ctrl_t cur, input logic evt,
                                         input logic clr, input logic wr,
                                         input logic din_ovr, input logic din_ie);
      ctrl_t n;
      n     = cur;
      n.rdy = evt | (cur.rdy & ~clr);
      if (wr) begin
         n.ie = din_ie;
      end
      if (evt && cur.rdy && !clr) begin
         n.ovr = 1'b1;
      end else if (wr && !din_ovr) begin
         n.ovr = 1'b0;
      end
      return n;
   endfunction

   assign kctrl_nxt = ctrl_update(kctrl, key_evt, key_clr, kctrl_wr, dmemin[1], dmemin[4]);
   assign sctrl_nxt = ctrl_update(sctrl, sw_evt,  sw_clr,  sctrl_wr, dmemin[1], dmemin[4]);

   always_ff @(posedge clk) begin
      if (reset) begin
         kctrl <= '0;
         sctrl <= '0;
      end else begin
         kctrl <= kctrl_nxt;
         sctrl <= sctrl_nxt;
      end
   end

   function automatic logic [15:0] ctrl_word(input ctrl_t c);
      return {11'b0, c.ie, 2'b0, c.ovr, c.rdy};
   endfunction

   always_comb begin
      dmemout = 16'hDEAD;
      case (dmemaddr)
         ADDR_KDATA: dmemout = {12'b0, ~deb[3:0]};
         ADDR_SDATA: dmemout = {6'b0, deb[13:4]};
         ADDR_KCTRL: dmemout = ctrl_word(kctrl);
         ADDR_SCTRL: dmemout = ctrl_word(sctrl);
         default:    dmemout = 16'hDEAD;
      endcase
   end

   assign irq = (kctrl.rdy & kctrl.ie) | (sctrl.rdy & sctrl.ie);

endmodule

// File: tb/tb_io_keysw_device.sv
// -----------------------------------------------------------------------------
// tb_io_keysw_device
//   Directed scenarios followed by randomized key/switch/bus activity. The
//   reference model keeps a history of raw input vectors. A debounced bit
//   changes when the raw values seen 2..DEB+1 edges ago all agree with each
//   other and differ from the current debounced value.
// -----------------------------------------------------------------------------
module tb_io_keysw_device;

   localparam int          N   = 4;
   localparam logic [13:0] RST = {10'b0, 4'hF};

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] dmemaddr, dmemin, dmemout;
   logic        wrmem, rdmem, irq;
   logic [3:0]  KEY;
   logic [9:0]  SW;

   int tests = 0;
   int fails = 0;

   // Reference model state
   logic [13:0] raw_q[$];
   logic [13:0] m_deb = RST;
   bit   [1:0]  m_rdy = '0, m_ovr = '0, m_ie = '0;   // index 0 keys, 1 switches

   io_keysw_device #(.DEB_CYCLES(16'd4)) dut (
      .clk(clk), .reset(reset), .dmemaddr(dmemaddr), .dmemin(dmemin),
      .wrmem(wrmem), .rdmem(rdmem), .dmemout(dmemout),
      .KEY(KEY), .SW(SW), .irq(irq)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_edge();
      logic [13:0] nd, first, s;
      bit          same;
      bit [1:0]    evt;
      bit          clr, wr;
      if (reset) begin
         raw_q.delete();
         for (int i = 0; i < N + 2; i++) raw_q.push_back(RST);
         m_deb = RST;
         m_rdy = '0; m_ovr = '0; m_ie = '0;
         return;
      end
      raw_q.push_back({SW, KEY});
      void'(raw_q.pop_front());
      // raw_q[0] is the raw value DEB+1 edges back, raw_q[N-1] is 2 edges back
      nd    = m_deb;
      first = raw_q[0];
      for (int b = 0; b < 14; b++) begin
         same = 1'b1;
         for (int i = 1; i < N; i++) begin
            s = raw_q[i];
            if (s[b] != first[b]) same = 1'b0;
         end
         if (same && first[b] != m_deb[b]) nd[b] = first[b];
      end
      evt[0] = (nd[3:0]  != m_deb[3:0]);
      evt[1] = (nd[13:4] != m_deb[13:4]);
      for (int c = 0; c < 2; c++) begin
         clr = rdmem && (dmemaddr == ((c == 0) ? 16'hFFF0 : 16'hFFF2));
         wr  = wrmem && (dmemaddr == ((c == 0) ? 16'hFFF4 : 16'hFFF6));
         if (evt[c] && m_rdy[c] && !clr) m_ovr[c] = 1'b1;
         else if (wr && !dmemin[1])     m_ovr[c] = 1'b0;
         if (wr) m_ie[c] = dmemin[4];
         if (evt[c])   m_rdy[c] = 1'b1;
         else if (clr) m_rdy[c] = 1'b0;
      end
      m_deb = nd;
   endfunction

   function automatic logic [15:0] model_read(input logic [15:0] a);
      case (a)
         16'hFFF0: return {12'b0, ~m_deb[3:0]};
         16'hFFF2: return {6'b0, m_deb[13:4]};
         16'hFFF4: return {11'b0, m_ie[0], 2'b0, m_ovr[0], m_rdy[0]};
         16'hFFF6: return {11'b0, m_ie[1], 2'b0, m_ovr[1], m_rdy[1]};
         default:  return 16'hDEAD;
      endcase
   endfunction

   function automatic logic model_irq();
      return (m_rdy[0] & m_ie[0]) | (m_rdy[1] & m_ie[1]);
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("auto_dout", dmemout, model_read(dmemaddr));
      check("auto_irq", {15'b0, irq}, {15'b0, model_irq()});
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
      dmemaddr = a;
      #1;
      check(tag, dmemout, exp);
   endtask

   task automatic store(input logic [15:0] a, input logic [15:0] d);
      dmemaddr = a; dmemin = d; wrmem = 1'b1;
      tick();
      wrmem = 1'b0;
   endtask

   task automatic load(input logic [15:0] a);
      dmemaddr = a; rdmem = 1'b1;
      tick();
      rdmem = 1'b0;
   endtask

   initial begin
      int idx;
      reset = 1'b1; KEY = 4'hF; SW = '0;
      dmemaddr = '0; dmemin = '0; wrmem = 1'b0; rdmem = 1'b0;
      tick(); tick();
      rd(16'hFFF0, 16'h0000, "rst_kdata");
      rd(16'hFFF2, 16'h0000, "rst_sdata");
      rd(16'hFFF4, 16'h0000, "rst_kctrl");
      rd(16'hFFF6, 16'h0000, "rst_sctrl");
      check("rst_irq", {15'b0, irq}, 16'h0000);

      // Press KEY[0]: visible exactly 6 cycles later
      reset = 1'b0; KEY = 4'b1110;
      for (int i = 1; i <= 5; i++) begin
         tick();
         rd(16'hFFF0, 16'h0000, "press_early");
      end
      tick();
      rd(16'hFFF0, 16'h0001, "press_kdata");
      rd(16'hFFF4, 16'h0001, "press_kctrl");
      load(16'hFFF0);
      rd(16'hFFF4, 16'h0000, "rdy_clear");

      // Glitch of 3 cycles on KEY[0] after a fresh reset
      reset = 1'b1; KEY = 4'hF;
      tick();
      reset = 1'b0; KEY = 4'b1110;
      repeat (3) tick();
      KEY = 4'hF;
      repeat (8) tick();
      rd(16'hFFF0, 16'h0000, "glitch_kdata");
      rd(16'hFFF4, 16'h0000, "glitch_kctrl");

      // Interrupt on KEY[1]
      store(16'hFFF4, 16'h0010);
      rd(16'hFFF4, 16'h0010, "ie_set");
      KEY = 4'b1101;
      repeat (5) tick();
      check("irq_early", {15'b0, irq}, 16'h0000);
      tick();
      check("irq_set", {15'b0, irq}, 16'h0001);
      dmemaddr = 16'hFFF0; rdmem = 1'b1;
      #1;
      check("irq_kdata", dmemout, 16'h0002);
      tick();
      rdmem = 1'b0;
      check("irq_clear", {15'b0, irq}, 16'h0000);

      // Switch overrun
      SW = 10'h001;
      repeat (6) tick();
      rd(16'hFFF6, 16'h0001, "sw_rdy");
      SW = 10'h003;
      repeat (6) tick();
      rd(16'hFFF6, 16'h0003, "sw_ovr");
      rd(16'hFFF2, 16'h0003, "sdata");
      store(16'hFFF6, 16'h0002);
      rd(16'hFFF6, 16'h0003, "ovr_keep");
      store(16'hFFF6, 16'h0000);
      rd(16'hFFF6, 16'h0001, "ovr_clear");

      // Store clearing OVR on the same edge as a new overrun
      SW = 10'h007;
      repeat (5) tick();
      store(16'hFFF6, 16'h0000);
      rd(16'hFFF6, 16'h0003, "ovr_set_wins");

      // Clearing load on the same edge as a new key change
      KEY = 4'hF;
      repeat (6) tick();
      rd(16'hFFF4, 16'h0011, "release_rdy");
      KEY = 4'b1110;
      repeat (5) tick();
      load(16'hFFF0);
      rd(16'hFFF4, 16'h0011, "set_wins_rdy");
      rd(16'hFFF0, 16'h0001, "set_wins_kdata");
      check("set_wins_irq", {15'b0, irq}, 16'h0001);

      // Decode and read-only data registers
      rd(16'hFFF8, 16'hDEAD, "unmapped_fff8");
      rd(16'hFFF1, 16'hDEAD, "unmapped_fff1");
      rd(16'h0000, 16'hDEAD, "unmapped_0000");
      store(16'hFFF0, 16'hFFFF);
      rd(16'hFFF0, 16'h0001, "kdata_ro");
      rd(16'hFFF4, 16'h0011, "kdata_store_no_clear");

      // Reset in the middle of a debounce countdown
      SW = 10'h000; KEY = 4'hF;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rd(16'hFFF0, 16'h0000, "midrst_kdata");
      rd(16'hFFF2, 16'h0000, "midrst_sdata");
      rd(16'hFFF4, 16'h0000, "midrst_kctrl");
      rd(16'hFFF6, 16'h0000, "midrst_sctrl");
      check("midrst_irq", {15'b0, irq}, 16'h0000);
      repeat (10) tick();
      rd(16'hFFF2, 16'h0000, "no_stale_sdata");
      rd(16'hFFF6, 16'h0000, "no_stale_sctrl");

      // Switches already on when reset releases
      reset = 1'b1; SW = 10'h3FF;
      tick();
      reset = 1'b0;
      repeat (5) tick();
      rd(16'hFFF6, 16'h0000, "sw_on_early");
      tick();
      rd(16'hFFF6, 16'h0001, "sw_on_rdy");
      rd(16'hFFF2, 16'h03FF, "sw_on_sdata");

      // Randomized traffic against the model
      repeat (3000) begin
         wrmem = 1'b0; rdmem = 1'b0;
         if ($urandom_range(0, 7) == 0) begin
            idx = $urandom_range(0, 13);
            if (idx < 4) KEY[idx] = ~KEY[idx];
            else         SW[idx-4] = ~SW[idx-4];
         end
         reset = ($urandom_range(0, 499) == 0);
         case ($urandom_range(0, 5))
            0:       dmemaddr = 16'hFFF0;
            1:       dmemaddr = 16'hFFF2;
            2:       dmemaddr = 16'hFFF4;
            3:       dmemaddr = 16'hFFF6;
            4:       dmemaddr = 16'hFFF8;
            default: dmemaddr = 16'($urandom);
         endcase
         dmemin = 16'($urandom);
         case ($urandom_range(0, 7))
            0:       rdmem = 1'b1;
            1:       wrmem = 1'b1;
            default: ;
         endcase
         tick();
      end
      reset = 1'b0; wrmem = 1'b0; rdmem = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/io_keysw_device.md
IO_KEYSW_DEVICE -- requirements
Module: io_keysw_device

Interface
REQ-001 Parameter DEB_CYCLES, default 16'd50000, is the number of consecutive stable synchronized samples required before a debounced bit changes; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 dmemaddr  input  16  byte address from the processor data-bus side.
REQ-005 dmemin  input  16  store data.
REQ-006 wrmem  input  1  store strobe, one cycle per store.
REQ-007 rdmem  input  1  load strobe, one cycle per load; it has side effects only as stated in REQ-016.
REQ-008 dmemout  output  16  load data, combinational from dmemaddr and register state.
REQ-009 KEY  input  4  raw board keys, asynchronous, active-low (0 = pressed).
REQ-010 SW  input  10  raw board switches, asynchronous, active-high.
REQ-011 irq  output  1  level interrupt request to the processor.

Function
REQ-012 Register map: 16'hFFF0 KDATA (read-only), 16'hFFF2 SDATA (read-only), 16'hFFF4 KCTRL (read/write), 16'hFFF6 SCTRL (read/write).
- Any other address reads 16'hDEAD.
- Stores to KDATA, SDATA or unmapped addresses are ignored.
REQ-013 Each KEY and SW bit passes through a two-flop synchronizer before use.
REQ-014 Debounce, per bit:
- A counter runs while the synchronized sample differs from the debounced value; it clears when they match.
- The debounced bit takes the sample at the edge where the sample has differed for DEB_CYCLES consecutive cycles.
- Raw change to debounced change latency is exactly 2 + DEB_CYCLES cycles.
- Any glitch shorter than DEB_CYCLES cycles produces no change.
REQ-015 KDATA = {12'b0, ~debounced KEY}, so pressed reads as 1. SDATA = {6'b0, debounced SW}.
REQ-016 KCTRL bits:
- bit0 RDY (read-only): set on any edge where any debounced KEY bit changes; cleared by a load (rdmem=1) from 16'hFFF0.
- bit1 OVR: set when a debounced KEY change occurs while RDY=1 and no clearing load happens in that cycle; cleared by a store with dmemin[1]=0; a store with dmemin[1]=1 has no effect on OVR.
- bit4 IE: read/write.
- All other bits read 0.
SCTRL has the same bit layout and behaviour, driven by SW and loads from 16'hFFF2.
REQ-017 Simultaneous clearing load and new change in the same cycle: RDY ends at 1 and OVR is unchanged (set wins over clear).
REQ-018 Simultaneous store clearing OVR and a new overrun event in the same cycle: OVR ends at 1.
REQ-019 irq = (KCTRL.RDY & KCTRL.IE) | (SCTRL.RDY & SCTRL.IE), driven registered-state-only with no combinational path from the bus.
REQ-020 A load with rdmem=0 (address decode only) has no side effects; dmemout is always valid for the current dmemaddr.
REQ-021 Stores take effect at the posedge where wrmem=1; the new value is readable the following cycle.

Reset
REQ-022 At reset, the following are cleared:
- KEY synchronizer and debounced KEY flops go to 4'hF (not pressed), so KDATA=0.
- SW synchronizer and debounced SW flops go to 0.
- All debounce counters, RDY, OVR and IE go to 0; irq=0.
REQ-023 Reset asserted mid-debounce or mid-transaction discards all progress; behaviour afterward is identical to power-up.
REQ-024 After reset deasserts, switches that are already on debounce normally and set SCTRL.RDY after 2 + DEB_CYCLES cycles.

Verification (DEB_CYCLES=4)
REQ-025 Press: KEY=4'b1110 steady after reset → KDATA=16'h0001 and KCTRL=16'h0001 exactly 6 cycles later, not earlier.
REQ-026 Glitch: KEY[0] low for 3 cycles, then high → KDATA stays 0 and RDY stays 0.
REQ-027 Interrupt: store 16'h0010 to FFF4, then press KEY[1] → irq=1 once debounced; a load with rdmem=1 from FFF0 reads 16'h0002 and irq=0 next cycle.
REQ-028 Overrun: SW=10'h001 debounced, no read, then SW=10'h003 debounced → SCTRL=16'h0003; store 16'h0000 to FFF6 → OVR=0, RDY=1.
REQ-029 Set-wins: a load from FFF0 with rdmem=1 in the same cycle a new KEY change debounces → RDY=1 next cycle.
REQ-030 Decode and reset: load from FFF8 → 16'hDEAD; assert reset during debounce countdown → all registers 0, irq=0, no stale update afterward.
